// File: rtl/mioc_flop_pkg.sv
// Shared definitions for the MIOC flop driver.
//   op_e         : command operation codes (WRITE, SET, RESET, READ)
//   state_e      : driver sequencer states
//   pins_t       : bundle of the four flop control lines in1..in4
//   PINS_IDLE    : idle levels of the control lines
//   phase_pins() : control-line levels for a given state/operation
//   rsp_check()  : error rule applied to the sampled q/qbar
package mioc_flop_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_SET   = 2'd1,
    OP_RESET = 2'd2,
    OP_READ  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ASSERT,
    ST_SETTLE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic in1;  // async reset, active-high
    logic in2;  // clock, flop captures on falling edge
    logic in3;  // data
    logic in4;  // async set, active-high
  } pins_t;

  localparam logic IDLE_IN1 = 1'b0;
  localparam logic IDLE_IN2 = 1'b1;
  localparam logic IDLE_IN3 = 1'b0;
  localparam logic IDLE_IN4 = 1'b0;

  localparam pins_t PINS_IDLE = '{in1: IDLE_IN1, in2: IDLE_IN2,
                                  in3: IDLE_IN3, in4: IDLE_IN4};

  // Control-line levels that belong to a phase of a command.
  function automatic pins_t phase_pins(input state_e st, input op_e op,
                                       input logic d);
    pins_t p;
    p = PINS_IDLE;
    case (st)
      ST_SETUP: p.in3 = d;
      ST_ASSERT: begin
        case (op)
          OP_WRITE: begin
            p.in3 = d;
            p.in2 = 1'b0;
          end
          OP_SET:   p.in4 = 1'b1;
          OP_RESET: p.in1 = 1'b1;
          default:  p = PINS_IDLE;
        endcase
      end
      ST_SETTLE, ST_RESP: begin
        if (op == OP_WRITE) p.in3 = d;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

  // RESET and READ report the sampled value without judging it.
  function automatic logic rsp_check(input op_e op, input logic d,
                                     input logic q, input logic qbar);
    logic err;
    err = 1'b0;
    case (op)
      OP_WRITE: err = (q != d) || (qbar == q);
      OP_SET:   err = (q != 1'b1) || (qbar == q);
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mioc_flop_phase_timer.sv
// Loadable 8-bit down-counter shared by the SETUP, ASSERT and SETTLE phases.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset (counter to 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load; a phase lasts load_val_i+1 cycles
//   done_o     : counter has reached 0
module mioc_flop_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mioc_flop_driver.sv
// Command-driven sequencer producing timed control waveforms for a MIOC
// 6-NOR flop cell and returning a checked sample of its outputs.
//   PULSE_CYC  : cycles per driven phase (1..255)
//   SETTLE_CYC : idle cycles between releasing the pins and sampling (1..255)
//   clk, rst_n             : clock, synchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake; cmd_op, cmd_d payload
//   rsp_valid/rsp_ready    : response handshake; rsp_q, rsp_err payload
//   in1..in4               : registered flop control lines (reset, clk, D, set)
//   q, qbar                : flop outputs
module mioc_flop_driver
  import mioc_flop_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_d,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  input  logic       q,
  input  logic       qbar
);

  if (PULSE_CYC < 1 || PULSE_CYC > 255) begin : g_bad_pulse_cyc
    $error("mioc_flop_driver: PULSE_CYC must be in 1..255");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle_cyc
    $error("mioc_flop_driver: SETTLE_CYC must be in 1..255");
  end

  // Pins are registered from the current state, so they trail the state by
  // one cycle. SETTLE therefore lasts SETTLE_CYC+1 cycles so that exactly
  // SETTLE_CYC idle-pin cycles precede the sample.
  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       dat_q, dat_d;
  pins_t      pins_q, pins_d;
  logic       rsp_q_q, rsp_q_d;
  logic       rsp_err_q, rsp_err_d;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  mioc_flop_phase_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dat_d     = dat_q;
    rsp_q_d   = rsp_q_q;
    rsp_err_d = rsp_err_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = op_e'(cmd_op);
          dat_d    = cmd_d;
          tmr_load = 1'b1;
          case (op_e'(cmd_op))
            OP_WRITE: begin
              state_d = ST_SETUP;
              tmr_val = PULSE_LOAD;
            end
            OP_SET, OP_RESET: begin
              state_d = ST_ASSERT;
              tmr_val = PULSE_LOAD;
            end
            default: begin
              state_d = ST_SETTLE;
              tmr_val = SETTLE_LOAD;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_ASSERT;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      ST_ASSERT: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d   = ST_RESP;
          rsp_q_d   = q;
          rsp_err_d = rsp_check(op_q, dat_q, q, qbar);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving RESP drops in3 on the same edge rather than one cycle late.
    if (state_d == ST_IDLE) begin
      pins_d = PINS_IDLE;
    end else begin
      pins_d = phase_pins(state_q, op_q, dat_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE;
      dat_q     <= 1'b0;
      pins_q    <= PINS_IDLE;
      rsp_q_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dat_q     <= dat_d;
      pins_q    <= pins_d;
      rsp_q_q   <= rsp_q_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
  assign in1       = pins_q.in1;
  assign in2       = pins_q.in2;
  assign in3       = pins_q.in3;
  assign in4       = pins_q.in4;

endmodule

// File: tb/tb_mioc_flop_driver.sv
// Bench for mioc_flop_driver: two drivers (default timing and 5/3 timing),
// each driving a behavioural 6-NOR flop model whose outputs can be faulted.
module tb_mioc_flop_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic       cmd_d     [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic       rsp_q     [2];
  logic       rsp_err   [2];
  logic       in1 [2], in2 [2], in3 [2], in4 [2];
  logic       q [2], qbar [2];

  int total = 0;
  int bad   = 0;

  // flop model state, output fault mode (0 none, 1 q stuck 0/qbar 1, 2 qbar=q)
  bit fq [2]  = '{1'b0, 1'b0};
  bit p2 [2]  = '{1'b1, 1'b1};
  int flt [2] = '{0, 0};
  bit fm [2]  = '{1'b0, 1'b0};   // expected flop content

  // pulse monitors
  int   n1 [2] = '{0, 0}, n2 [2] = '{0, 0}, n4 [2] = '{0, 0};
  int   w1 [2] = '{0, 0}, w2 [2] = '{0, 0}, w4 [2] = '{0, 0};
  int   c1 [2] = '{0, 0}, c2 [2] = '{0, 0}, c4 [2] = '{0, 0};
  int   s3c [2] = '{0, 0}, setup3 [2] = '{0, 0};
  logic in3p [2], in2p [2], in3f [2];

  mioc_flop_driver #(.PULSE_CYC(2), .SETTLE_CYC(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]), .cmd_d(cmd_d[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_q(rsp_q[0]), .rsp_err(rsp_err[0]),
    .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .in4(in4[0]), .q(q[0]), .qbar(qbar[0])
  );

  mioc_flop_driver #(.PULSE_CYC(5), .SETTLE_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]), .cmd_d(cmd_d[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_q(rsp_q[1]), .rsp_err(rsp_err[1]),
    .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .in4(in4[1]), .q(q[1]), .qbar(qbar[1])
  );

  function automatic int pcyc(input int i);
    return (i == 0) ? 2 : 5;
  endfunction

  function automatic int scyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Behavioural flop: async reset dominates, then async set, else D on in2 fall.
  always @(in1[0] or in2[0] or in4[0] or in1[1] or in2[1] or in4[1]) begin
    for (int i = 0; i < 2; i++) begin
      if (in1[i] === 1'b1) fq[i] = 1'b0;
      else if (in4[i] === 1'b1) fq[i] = 1'b1;
      else if (p2[i] && in2[i] === 1'b0) fq[i] = in3[i];
      p2[i] = (in2[i] !== 1'b0);
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q[i]    = (flt[i] == 1) ? 1'b0 : fq[i];
      qbar[i] = (flt[i] == 1) ? 1'b1 : (flt[i] == 2) ? fq[i] : ~fq[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (in2[i] === 1'b0) c2[i]++;
      else if (c2[i] != 0) begin w2[i] = c2[i]; n2[i]++; c2[i] = 0; end
      if (in4[i] === 1'b1) c4[i]++;
      else if (c4[i] != 0) begin w4[i] = c4[i]; n4[i]++; c4[i] = 0; end
      if (in1[i] === 1'b1) c1[i]++;
      else if (c1[i] != 0) begin w1[i] = c1[i]; n1[i]++; c1[i] = 0; end
      if (in2p[i] === 1'b1 && in2[i] === 1'b0) begin
        setup3[i] = s3c[i];
        in3f[i]   = in3[i];
      end
      if (in3[i] === in3p[i]) s3c[i]++;
      else s3c[i] = 1;
      in3p[i] = in3[i];
      in2p[i] = in2[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One command end to end: latency, payload, pulse shapes, response hold.
  task automatic do_cmd(input int i, input int op, input bit d, input int hold, input int fmode);
    int  k, exp_n, pc, sc, bad_rdy, unst;
    int  b1, b2, b4;
    bit  got, eq, eqb, ee;
    pc = pcyc(i);
    sc = scyc(i);
    @(negedge clk);
    check("ready_before_cmd", cmd_ready[i], 1);
    b1 = n1[i]; b2 = n2[i]; b4 = n4[i];
    flt[i]       = fmode;
    cmd_valid[i] = 1'b1;
    cmd_op[i]    = 2'(op);
    cmd_d[i]     = d;
    rsp_ready[i] = (hold == 0);
    @(posedge clk);
    case (op)
      0: fm[i] = d;
      1: fm[i] = 1'b1;
      2: fm[i] = 1'b0;
      default: ;
    endcase
    exp_n = (op == 0) ? 2 * pc + sc + 1 : (op == 3) ? sc + 1 : pc + sc + 1;
    k = 0; got = 1'b0; bad_rdy = 0;
    while (k < 1000) begin
      @(negedge clk);
      cmd_op[i] = 2'($urandom);
      cmd_d[i]  = 1'($urandom);
      if (rsp_valid[i] === 1'b1) begin got = 1'b1; break; end
      if (cmd_ready[i] !== 1'b0) bad_rdy++;
      cmd_valid[i] = 1'($urandom);
      @(posedge clk);
      k++;
    end
    cmd_valid[i] = 1'b0;
    check("rsp_seen", got, 1);
    check("latency", k, exp_n);
    check("ready_low_busy", bad_rdy, 0);
    eq  = (fmode == 1) ? 1'b0 : fm[i];
    eqb = (fmode == 1) ? 1'b1 : (fmode == 2) ? fm[i] : ~fm[i];
    if (op == 0)      ee = (eq != d) || (eqb == eq);
    else if (op == 1) ee = (eq != 1'b1) || (eqb == eq);
    else              ee = 1'b0;
    check("rsp_q", rsp_q[i], eq);
    check("rsp_err", rsp_err[i], ee);
    check("in2_pulses", n2[i] - b2, (op == 0) ? 1 : 0);
    check("in4_pulses", n4[i] - b4, (op == 1) ? 1 : 0);
    check("in1_pulses", n1[i] - b1, (op == 2) ? 1 : 0);
    if (op == 0) begin
      check("in2_low_width", w2[i], pc);
      check("in3_at_capture", in3f[i], d);
      check("in3_setup_ok", setup3[i] >= pc, 1);
    end
    if (op == 1) check("in4_width", w4[i], pc);
    if (op == 2) check("in1_width", w1[i], pc);
    if (hold > 0) begin
      unst = 0;
      for (int h = 0; h < hold; h++) begin
        cmd_valid[i] = (h == 0);
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid[i] !== 1'b1 || rsp_q[i] !== eq || rsp_err[i] !== ee ||
            cmd_ready[i] !== 1'b0) unst++;
      end
      cmd_valid[i] = 1'b0;
      check("rsp_hold_stable", unst, 0);
      rsp_ready[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("rsp_consumed", rsp_valid[i], 0);
    check("ready_after_rsp", cmd_ready[i], 1);
    check("in3_back_idle", in3[i], 0);
    rsp_ready[i] = 1'b0;
    flt[i]       = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0; cmd_op[i] = 2'd0; cmd_d[i] = 1'b0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_cmd_ready", cmd_ready[i], 1);
      check("reset_rsp_valid", rsp_valid[i], 0);
      check("reset_rsp_q", rsp_q[i], 0);
      check("reset_rsp_err", rsp_err[i], 0);
      check("reset_pins", {in1[i], in2[i], in3[i], in4[i]}, 4'b0100);
    end
    rst_n = 1'b1;

    // directed, default timing
    do_cmd(0, 0, 1'b1, 0, 0);
    do_cmd(0, 0, 1'b0, 0, 0);
    do_cmd(0, 1, 1'b0, 0, 0);
    do_cmd(0, 3, 1'b0, 0, 0);
    do_cmd(0, 0, 1'b1, 0, 1);
    do_cmd(0, 0, 1'b1, 0, 2);
    do_cmd(0, 1, 1'b0, 0, 2);
    do_cmd(0, 0, 1'b0, 5, 0);

    // reset during the ASSERT phase of a SET
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in4", in4[0], 0);
    check("abort_in2", in2[0], 1);
    check("abort_in1", in1[0], 0);
    check("abort_cmd_ready", cmd_ready[0], 1);
    check("abort_rsp_valid", rsp_valid[0], 0);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) quiet++;
    end
    check("abort_no_response", quiet, 0);
    do_cmd(0, 2, 1'b0, 0, 0);
    do_cmd(0, 3, 1'b0, 2, 0);

    // directed, PULSE_CYC=5 SETTLE_CYC=3
    do_cmd(1, 0, 1'b1, 0, 0);
    do_cmd(1, 1, 1'b0, 0, 0);
    do_cmd(1, 0, 1'b0, 1, 0);
    do_cmd(1, 3, 1'b0, 0, 0);

    // randomized
    for (int n = 0; n < 60; n++) begin
      int op, hold, fmode, inst;
      bit d;
      inst  = (n % 4 == 3) ? 1 : 0;
      op    = $urandom_range(0, 3);
      d     = 1'($urandom);
      hold  = $urandom_range(0, 3);
      fmode = ($urandom_range(0, 7) == 0) ? 1 : ($urandom_range(0, 7) == 0) ? 2 : 0;
      do_cmd(inst, op, d, hold, fmode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
